// File: rtl/weighted_rank_pipe.sv
// Weighted population count: each set comparator bit contributes a programmable
// weight; the weights are summed through a fully registered binary adder tree with a global stall.
module weighted_rank_pipe #(
    parameter int N_IN     = 8,
    parameter int WEIGHT_W = 4,
    parameter int OUT_W    = WEIGHT_W + $clog2(N_IN + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_IN-1:0]           in_bits,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      cfg_we,
    input  logic [$clog2(N_IN)-1:0]   cfg_addr,
    input  logic [WEIGHT_W-1:0]       cfg_data,
    output logic [OUT_W-1:0]          out_sum,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int DEPTH = $clog2(N_IN);

    logic [WEIGHT_W-1:0] r_weight [N_IN];
    logic                w_stall;

    // Stage 0 reads r_weight before this edge's write lands, so a sample
    // accepted together with a weight write still sees the old weight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                r_weight[i] <= WEIGHT_W'(1);
            end
        end else if (cfg_we && (int'(cfg_addr) < N_IN)) begin
            r_weight[cfg_addr] <= cfg_data;
        end
    end

    // Level gi holds ceil(N_IN / 2**gi) partial sums; adjacent pairs are
    // added and an unpaired last node is carried up unchanged.
    for (genvar gi = 0; gi <= DEPTH; gi++) begin : g_lvl
        localparam int CNT = (N_IN + (1 << gi) - 1) >> gi;

        logic [OUT_W-1:0] r_node      [CNT];
        logic [OUT_W-1:0] w_node_next [CNT];
        logic             r_vld;
        logic             w_vld_next;

        if (gi == 0) begin : g_leaf
            for (genvar gj = 0; gj < CNT; gj++) begin : g_node
                assign w_node_next[gj] = in_bits[gj] ? OUT_W'(r_weight[gj]) : '0;
            end
            assign w_vld_next = in_valid;
        end else begin : g_add
            localparam int PCNT = (N_IN + (1 << (gi - 1)) - 1) >> (gi - 1);
            for (genvar gj = 0; gj < CNT; gj++) begin : g_node
                if (2 * gj + 1 < PCNT) begin : g_sum
                    assign w_node_next[gj] = g_lvl[gi-1].r_node[2*gj] + g_lvl[gi-1].r_node[2*gj+1];
                end else begin : g_pass
                    assign w_node_next[gj] = g_lvl[gi-1].r_node[2*gj];
                end
            end
            assign w_vld_next = g_lvl[gi-1].r_vld;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                for (int j = 0; j < CNT; j++) begin
                    r_node[j] <= '0;
                end
            end else if (!w_stall) begin
                r_vld <= w_vld_next;
                for (int j = 0; j < CNT; j++) begin
                    r_node[j] <= w_node_next[j];
                end
            end
        end
    end

    assign out_valid = g_lvl[DEPTH].r_vld;
    assign out_sum   = g_lvl[DEPTH].r_node[0];
    assign w_stall   = out_valid && !out_ready;
    assign in_ready  = !w_stall;

endmodule

// File: doc/weighted_rank_pipe.md
WEIGHTED_RANK_PIPE -- requirements
Module: weighted_rank_pipe

Interface
- REQ-001 N_IN, default 8, number of comparator bits summed; 2..64.
- REQ-002 WEIGHT_W, default 4, width of each per-input unsigned weight.
- REQ-003 OUT_W, default WEIGHT_W+$clog2(N_IN+1), sum width; SHALL be at least $clog2(N_IN*(2**WEIGHT_W-1)+1).
- REQ-004 clk  in  1  sole clock, rising edge.
- REQ-005 rst_n  in  1  reset, synchronous, active-low.
- REQ-006 in_bits  in  N_IN  comparator results; bit i contributes weight[i] when set.
- REQ-007 in_valid  in  1  in_bits is valid this cycle.
- REQ-008 in_ready  out  1  block accepts in_bits this cycle.
- REQ-009 cfg_we  in  1  weight write strobe.
- REQ-010 cfg_addr  in  $clog2(N_IN)  weight index.
- REQ-011 cfg_data  in  WEIGHT_W  weight value.
- REQ-012 out_sum  out  OUT_W  weighted sum of one accepted sample.
- REQ-013 out_valid  out  1  out_sum is valid.
- REQ-014 out_ready  in  1  downstream accepts out_sum.

Function
- REQ-015 Transfer on input side occurs when in_valid && in_ready; on output side when out_valid && out_ready.
- REQ-016 out_sum SHALL equal the sum over i of (in_bits[i] ? weight[i] : 0), zero-extended to OUT_W; no overflow is possible given REQ-003.
- REQ-017 Pipeline: stage 0 registers masked weights; then one register level per binary-tree level; LAT = 1 + $clog2(N_IN) cycles from input transfer to out_valid assertion (N_IN=8: LAT=4).
- REQ-018 Tree split: lower subtree takes 2**($clog2(n)-1) inputs, upper the remainder; odd leaves pass through registered, not summed with zero-width logic errors.
- REQ-019 Each stage carries a valid bit; out_valid is the last stage's valid bit.
- REQ-020 Global stall: stall = out_valid && !out_ready; while stall, every stage register and valid bit holds; in_ready = !stall.
- REQ-021 Bubbles SHALL collapse: when not stalled, stages advance regardless of their own valid bit.
- REQ-022 Throughput one sample per cycle when out_ready held high.
- REQ-023 Order preserved; no sample dropped or duplicated under any in_valid/out_ready pattern.
- REQ-024 Weight write: on cfg_we, weight[cfg_addr] <= cfg_data at clock edge; cfg_addr >= N_IN ignored.
- REQ-025 A sample accepted in the same cycle as a weight write uses the old weight; samples accepted from the next cycle use the new one; in-flight samples unaffected.
- REQ-026 Weight writes are accepted during stall.
- REQ-027 With all weights = 1 the block is an N_IN-input popcount.

Reset
- REQ-028 On rising clk with rst_n low: all valid bits 0, out_valid 0, out_sum 0, all stage data 0.
- REQ-029 On reset every weight[i] = 1.
- REQ-030 in_ready SHALL be 1 during and immediately after reset (out_valid 0 implies no stall).
- REQ-031 Reset mid-operation discards all in-flight samples; no out_valid for them after rst_n returns high.
- REQ-032 cfg_we during reset is ignored.

Verification (N_IN=8, WEIGHT_W=4)
- REQ-033 After reset, in_bits=8'hFF valid one cycle, out_ready=1 -> out_valid high exactly 4 cycles later, out_sum=8.
- REQ-034 Write weight[i]=i+1 for i=0..7, then in_bits=8'hA5 -> out_sum=1+3+6+8=18; in_bits=8'hFF -> 36; all weights 15, 8'hFF -> 120.
- REQ-035 Stream 20 random samples back-to-back, out_ready low for 3 cycles mid-stream -> in_ready low exactly while out_valid&&!out_ready; all 20 sums correct, in order.
- REQ-036 Write weight[2]=9 in same cycle as sample 8'h04 accepted, next sample 8'h04 -> sums 1 then 9.
- REQ-037 Two samples in flight, rst_n low one cycle -> out_valid stays 0 until a new sample; weights back to 1.
- REQ-038 Sparse input (in_valid every 3rd cycle) with out_ready=1 -> each sum appears exactly LAT cycles after its input, one cycle wide.
